// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit. Sub-word stores use read-modify-write against a word memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of force-aligning them.
module load_store_unit #(
   parameter int unsigned WORD_ADDR_BITS = 16
) (
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   input  logic        i_Request,
   output logic        o_Ready,
   input  logic        i_Write,
   input  logic [1:0]  i_Size,
   input  logic        i_Unsigned,
   input  logic [31:0] i_Address,
   input  logic [31:0] i_WriteData,
   output logic        o_Done,
   output logic [31:0] o_ReadData,
   output logic        o_Misaligned,
   output logic        o_MemWriteEnable,
   output logic [31:0] o_MemAddress,
   output logic [31:0] o_MemDataOut,
   input  logic [31:0] i_MemDataIn
);

   typedef enum logic [2:0] {StIdle, StIssue, StCapture, StWrite, StResp} state_e;

   state_e      state_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [1:0]  size_q;
   logic        unsigned_q, write_q, done_q, misal_q;

   logic [31:0] acc_addr;
   logic [1:0]  acc_size;
   logic        acc_misal;
   logic [31:0] word_addr, load_val, store_mask, store_shifted, merged;
   logic [4:0]  shamt;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

`ifdef LSU_MISALIGN_TRAP_EN
   assign acc_size  = i_Size;
   assign acc_addr  = i_Address;
   assign acc_misal = (i_Size == 2'b11) || (i_Size == 2'b01 && i_Address[0]) ||
                      (i_Size == 2'b10 && i_Address[1:0] != 2'b00);
`else
   // Size 11 is treated as a word; low address bits are dropped to the size boundary.
   assign acc_size  = (i_Size == 2'b11) ? 2'b10 : i_Size;
   assign acc_misal = 1'b0;
   always_comb begin
      case (acc_size)
         2'b00:   acc_addr = i_Address;
         2'b01:   acc_addr = {i_Address[31:1], 1'b0};
         default: acc_addr = {i_Address[31:2], 2'b00};
      endcase
   end
`endif

   // Low WORD_ADDR_BITS form the decoded word index; upper bits ride along untouched.
   generate
      if (WORD_ADDR_BITS >= 30) begin : g_full
         assign word_addr = {2'b00, addr_q[31:2]};
      end else begin : g_split
         assign word_addr = {2'b00, addr_q[31:WORD_ADDR_BITS+2], addr_q[WORD_ADDR_BITS+1:2]};
      end
   endgenerate

   assign shamt   = {addr_q[1:0], 3'b000};
   assign ld_byte = 8'(i_MemDataIn >> shamt);
   assign ld_half = addr_q[1] ? i_MemDataIn[31:16] : i_MemDataIn[15:0];

   always_comb begin
      load_val      = i_MemDataIn;
      store_mask    = 32'hFFFF_FFFF;
      store_shifted = wdata_q;
      case (size_q)
         2'b00: begin
            load_val      = unsigned_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            store_mask    = 32'h0000_00FF << shamt;
            store_shifted = {24'h0, wdata_q[7:0]} << shamt;
         end
         2'b01: begin
            load_val      = unsigned_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            store_mask    = 32'h0000_FFFF << {addr_q[1], 4'b0000};
            store_shifted = {16'h0, wdata_q[15:0]} << {addr_q[1], 4'b0000};
         end
         default: ;
      endcase
   end

   assign merged = (i_MemDataIn & ~store_mask) | (store_shifted & store_mask);

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         state_q    <= StIdle;
         addr_q     <= 32'h0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         write_q    <= 1'b0;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         done_q     <= 1'b0;
         misal_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         misal_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (i_Request) begin
                  addr_q     <= acc_addr;
                  size_q     <= acc_size;
                  unsigned_q <= i_Unsigned;
                  write_q    <= i_Write;
                  wdata_q    <= i_WriteData;
                  if (acc_misal) begin
                     state_q <= StResp;
                     done_q  <= 1'b1;
                     misal_q <= 1'b1;
                  end else if (i_Write && acc_size == 2'b10) begin
                     state_q <= StWrite;
                  end else begin
                     state_q <= StIssue;
                  end
               end
            end
            StIssue: state_q <= StCapture;
            StCapture: begin
               if (write_q) begin
                  wdata_q <= merged;
                  state_q <= StWrite;
               end else begin
                  rdata_q <= load_val;
                  done_q  <= 1'b1;
                  state_q <= StResp;
               end
            end
            StWrite: begin
               done_q  <= 1'b1;
               state_q <= StResp;
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_Ready          = (state_q == StIdle);
   assign o_Done           = done_q;
   assign o_Misaligned     = misal_q;
   assign o_ReadData       = rdata_q;
   assign o_MemWriteEnable = (state_q == StWrite);
   assign o_MemDataOut     = (state_q == StWrite) ? wdata_q : 32'h0;
   assign o_MemAddress     = (state_q != StIdle) ? word_addr : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle registered word memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, wr = 1'b0, uns = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic        ready, done, misal, we;
   logic [31:0] rdata, maddr, mdout, mdin;

   logic [31:0] mem [0:255];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_a = 8'h0;
   logic [31:0] pre_d = 32'h0;
   logic        wr_clr = 1'b0;
   int          wr_cnt = 0;
   logic [31:0] last_wa = 32'h0, last_wd = 32'h0;

   int n_vec = 0;
   int n_bad = 0;

   int          lat, wrs;
   logic [31:0] rd;
   logic        mis;

   always #5 clk = ~clk;

   load_store_unit #(.WORD_ADDR_BITS(16)) dut (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_Request(req), .o_Ready(ready),
      .i_Write(wr), .i_Size(size), .i_Unsigned(uns), .i_Address(addr),
      .i_WriteData(wdata), .o_Done(done), .o_ReadData(rdata), .o_Misaligned(misal),
      .o_MemWriteEnable(we), .o_MemAddress(maddr), .o_MemDataOut(mdout), .i_MemDataIn(mdin)
   );

   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_a] <= pre_d;
      end else if (we) begin
         mem[maddr[7:0]] <= mdout;
         wr_cnt  <= wr_cnt + 1;
         last_wa <= maddr;
         last_wd <= mdout;
      end
      if (wr_clr) wr_cnt <= 0;
      mdin <= mem[maddr[7:0]];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_a = a; pre_d = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // Returns done latency in negedges after the accept edge (0 = timed out).
   task automatic access(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, output int l, output logic [31:0] r,
                         output logic m, output int nw);
      @(negedge clk);
      check_eq("ready_before_req", 32'(ready), 32'd1);
      req = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = wd; wr_clr = 1'b1;
      @(posedge clk); #1;
      // Garbage after acceptance must be ignored.
      req = 1'b0; wr_clr = 1'b0; size = 2'b11; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
      wr = ~w; uns = ~u;
      l = 0; r = 32'h0; m = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (done) begin
            l = k; r = rdata; m = misal;
            break;
         end
      end
      nw = wr_cnt;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("rst_ready", 32'(ready), 32'd1);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_rdata", rdata, 32'h0);
      check_eq("rst_we", 32'(we), 32'd0);
      check_eq("rst_misal", 32'(misal), 32'd0);

      preload(8'd0, 32'h8899_AABB);
      preload(8'd1, 32'h1122_3344);

      access(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, lat, rd, mis, wrs);
      check_eq("lb_s_lat", 32'(lat), 32'd3);
      check_eq("lb_s_data", rd, 32'hFFFF_FFAA);
      check_eq("lb_s_nowrite", 32'(wrs), 32'd0);

      access(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, lat, rd, mis, wrs);
      check_eq("lh_u_lat", 32'(lat), 32'd3);
      check_eq("lh_u_data", rd, 32'h0000_8899);

      access(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, lat, rd, mis, wrs);
      check_eq("lb_u_data", rd, 32'h0000_0088);

      access(1'b0, 2'b01, 1'b0, 32'h0, 32'h0, lat, rd, mis, wrs);
      check_eq("lh_s_data", rd, 32'hFFFF_AABB);

      access(1'b1, 2'b00, 1'b0, 32'h2, 32'hAABB_CC5C, lat, rd, mis, wrs);
      check_eq("sb_lat", 32'(lat), 32'd4);
      check_eq("sb_writes", 32'(wrs), 32'd1);
      check_eq("sb_waddr", last_wa, 32'h0);
      check_eq("sb_wdata", last_wd, 32'h885C_AABB);
      check_eq("sb_rdata_held", rdata, 32'hFFFF_AABB);

      access(1'b1, 2'b01, 1'b0, 32'h6, 32'h5555_1234, lat, rd, mis, wrs);
      check_eq("sh_lat", 32'(lat), 32'd4);
      check_eq("sh_wdata", last_wd, 32'h1234_3344);
      check_eq("sh_waddr", last_wa, 32'h1);

      access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, mis, wrs);
      check_eq("sw_lat", 32'(lat), 32'd2);
      check_eq("sw_writes", 32'(wrs), 32'd1);
      check_eq("sw_waddr", last_wa, 32'h4);
      check_eq("sw_wdata", last_wd, 32'hDEAD_BEEF);

      access(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, rd, mis, wrs);
      check_eq("lw_lat", 32'(lat), 32'd3);
      check_eq("lw_data", rd, 32'hDEAD_BEEF);

      access(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, lat, rd, mis, wrs);
      check_eq("mis_nowrite", 32'(wrs), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      check_eq("mis_lat", 32'(lat), 32'd1);
      check_eq("mis_flag", 32'(mis), 32'd1);
      check_eq("mis_rdata_kept", rd, 32'hDEAD_BEEF);
`else
      check_eq("mis_lat", 32'(lat), 32'd3);
      check_eq("mis_flag", 32'(mis), 32'd0);
      check_eq("mis_aligned_data", rd, 32'h1234_3344);
`endif

      // Reset while a byte store sits in CAPTURE.
      @(negedge clk);
      req = 1'b1; wr = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h0; wdata = 32'h77;
      wr_clr = 1'b1;
      @(posedge clk); #1;
      req = 1'b0; wr_clr = 1'b0;
      @(negedge clk);
      check_eq("abort_issue_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("abort_ready", 32'(ready), 32'd1);
      check_eq("abort_done", 32'(done), 32'd0);
      check_eq("abort_rdata", rdata, 32'h0);
      @(negedge clk);
      check_eq("abort_done_later", 32'(done), 32'd0);
      check_eq("abort_nowrite", 32'(wr_cnt), 32'd0);
      check_eq("abort_mem", mem[0], 32'h885C_AABB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORD_ADDR_BITS, default 16: number of word-address bits the memory decodes; wider address bits pass through unused.
REQ-002 SHALL have port i_Clock  in  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port i_Reset_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port i_Request  in  1  CPU access request, accepted when i_Request && o_Ready at a rising edge.
REQ-005 SHALL have port o_Ready  out  1  high only in IDLE.
REQ-006 SHALL have port i_Write  in  1  1 = store, 0 = load.
REQ-007 SHALL have port i_Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port i_Unsigned  in  1  load zero-extend (1) or sign-extend (0).
REQ-009 SHALL have port i_Address  in  32  byte address.
REQ-010 SHALL have port i_WriteData  in  32  store data, right-justified.
REQ-011 SHALL have port o_Done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port o_ReadData  out  32  extended load result, valid while o_Done high, held until the next load completes.
REQ-013 SHALL have port o_Misaligned  out  1  pulses with o_Done when the access was rejected.
REQ-014 SHALL have ports o_MemWriteEnable out 1, o_MemAddress out 32, o_MemDataOut out 32, i_MemDataIn in 32: word-wide memory with one-cycle registered read.

Function
REQ-015 SHALL latch address, size, unsigned, write and write data at acceptance; inputs afterwards are ignored until o_Ready returns high.
REQ-016 SHALL drive o_MemAddress = {2'b00, latched address[31:2]} in every non-IDLE state.
REQ-017 SHALL implement states IDLE, ISSUE, CAPTURE, WRITE, RESP.
REQ-018 Load: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE; o_Done high 3 cycles after the accept edge.
REQ-019 Word store: IDLE -> WRITE -> RESP -> IDLE; o_Done high 2 cycles after accept.
REQ-020 Byte/half store (read-modify-write): IDLE -> ISSUE -> CAPTURE -> WRITE -> RESP -> IDLE; o_Done 4 cycles after accept.
REQ-021 SHALL assert o_MemWriteEnable only in WRITE; o_MemDataOut is the merged or full word in WRITE and 0 elsewhere.
REQ-022 In CAPTURE, i_MemDataIn SHALL be treated as the addressed word; little-endian lanes, lane n = bits [8n+7:8n].
REQ-023 Byte load selects lane addr[1:0]; halfword load selects bits [16*addr[1]+15:16*addr[1]]; extend to 32 bits per i_Unsigned; word load ignores i_Unsigned.
REQ-024 Byte store replaces lane addr[1:0] with i_WriteData[7:0]; halfword store replaces halfword addr[1] with i_WriteData[15:0]; other bits preserved.
REQ-025 Misaligned = size 11, or halfword with addr[0]=1, or word with addr[1:0]!=0; handling per REQ-031.
REQ-026 i_Request while o_Ready is low (including the RESP cycle) SHALL be ignored; a new request may be accepted in the cycle following RESP.

Reset
REQ-027 While i_Reset_n is low at a rising edge, the FSM SHALL enter IDLE and o_Done, o_Misaligned, o_ReadData, latched request registers SHALL clear to 0.
REQ-028 o_Ready SHALL be 1 in the cycle after reset; o_MemWriteEnable 0.
REQ-029 Reset during any state SHALL abort with no o_Done; a reset edge coinciding with WRITE still commits that write in memory (WE already high), no further writes follow.

Configuration
REQ-030 SHALL use macro LSU_MISALIGN_TRAP_EN.
REQ-031 Defined: misaligned requests go IDLE -> RESP, no memory access, o_Done and o_Misaligned high together, o_ReadData unchanged; undefined: address low bits are forced to the aligned boundary of the size (size 11 treated as word), access proceeds normally, o_Misaligned tied 0.

Verification
REQ-032 Preload word 0x0 = 0x8899AABB; byte load addr 0x1, i_Unsigned=0 -> o_ReadData 0xFFFFFFAA, o_Done 3 cycles after accept.
REQ-033 Same word; halfword load addr 0x2, i_Unsigned=1 -> 0x00008899.
REQ-034 Byte store 0x5C to addr 0x2 over word 0x8899AABB -> one write of 0x885CAABB to word address 0, o_Done 4 cycles after accept.
REQ-035 Word store 0xDEADBEEF to 0x10 -> WE high one cycle, o_MemAddress 0x4, o_Done 2 cycles after accept, then load returns 0xDEADBEEF.
REQ-036 With LSU_MISALIGN_TRAP_EN: word load addr 0x6 -> o_Done and o_Misaligned same cycle, 1 cycle after accept, WE never high; without: returns word at address 0x4.
REQ-037 Reset asserted in CAPTURE of a byte store -> no write, no o_Done, o_Ready high next cycle.
